// File: rtl/router_register_if.sv
// Packet-side bus of the router register stage: source byte, FSM state decodes
// and the byte/status outputs toward the output FIFOs.
interface router_register_if #(
  parameter int WIDTH = 8
);
  logic             pkt_valid;
  logic [WIDTH-1:0] data_in;
  logic             fifo_full;
  logic             detect_add;
  logic             lfd_state;
  logic             ld_state;
  logic             laf_state;
  logic             full_state;
  logic             rst_int_reg;
  logic [WIDTH-1:0] dout;
  logic             parity_done;
  logic             low_pkt_valid;
  logic             err;

  modport master (
    output pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    input  dout, parity_done, low_pkt_valid, err
  );

  modport slave (
    input  pkt_valid, data_in, fifo_full, detect_add, lfd_state, ld_state,
           laf_state, full_state, rst_int_reg,
    output dout, parity_done, low_pkt_valid, err
  );
endinterface

// File: rtl/router_register.sv
// Router datapath register: latches the header, forwards bytes to the FIFO,
// parks one byte while the FIFO is full and checks the packet's XOR parity.
module router_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  router_register_if.slave bus
);
  logic [WIDTH-1:0] header_byte;
  logic [WIDTH-1:0] full_byte;
  logic [WIDTH-1:0] internal_parity;
  logic [WIDTH-1:0] packet_parity;

  logic parity_from_src;
  logic parity_from_hold;

  // Parity byte either goes straight through, or is replayed from full_byte
  // after a stall that caught it.
  assign parity_from_src  = bus.ld_state & ~bus.pkt_valid & ~bus.fifo_full;
  assign parity_from_hold = bus.laf_state & bus.low_pkt_valid & ~bus.parity_done;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      header_byte       <= '0;
      full_byte         <= '0;
      internal_parity   <= '0;
      packet_parity     <= '0;
      bus.dout          <= '0;
      bus.parity_done   <= 1'b0;
      bus.low_pkt_valid <= 1'b0;
      bus.err           <= 1'b0;
    end else begin
      if (bus.detect_add && bus.pkt_valid && bus.data_in[1:0] != 2'b11)
        header_byte <= bus.data_in;

      if (bus.lfd_state)
        bus.dout <= header_byte;
      else if (bus.ld_state && !bus.fifo_full)
        bus.dout <= bus.data_in;
      else if (bus.ld_state && bus.fifo_full)
        full_byte <= bus.data_in;
      else if (bus.laf_state)
        bus.dout <= full_byte;

      // Payload bytes are counted on acceptance, so the laf replay is not counted again.
      if (bus.detect_add)
        internal_parity <= '0;
      else if (bus.lfd_state)
        internal_parity <= internal_parity ^ header_byte;
      else if (bus.ld_state && bus.pkt_valid && !bus.full_state)
        internal_parity <= internal_parity ^ bus.data_in;

      if (bus.detect_add)
        packet_parity <= '0;
      else if (parity_from_src)
        packet_parity <= bus.data_in;
      else if (parity_from_hold)
        packet_parity <= full_byte;

      if (bus.detect_add)
        bus.parity_done <= 1'b0;
      else if (parity_from_src || parity_from_hold)
        bus.parity_done <= 1'b1;

      if (bus.rst_int_reg)
        bus.low_pkt_valid <= 1'b0;
      else if (bus.ld_state && !bus.pkt_valid)
        bus.low_pkt_valid <= 1'b1;

      if (bus.lfd_state)
        bus.err <= 1'b0;
      else if (bus.parity_done)
        bus.err <= (internal_parity != packet_parity);
    end
  end
endmodule

// File: tb/tb_router_register.sv
// Self-checking bench for router_register: directed packet table, a reset
// sequence and randomized packets against a packet-level reference model.
module tb_router_register;
  logic clk = 1'b0;
  logic resetn;
  always #5 clk = ~clk;

  router_register_if #(.WIDTH(8)) bus ();
  router_register #(.WIDTH(8)) dut (.clk(clk), .resetn(resetn), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [7:0] last_hdr;

  typedef struct {
    logic [7:0]      hdr;
    int              len;
    logic [7:0][7:0] pay;
    logic [7:0]      par;
    logic [7:0]      stall;
    logic            par_stall;
    int              full_cyc;
    logic            exp_err;
  } pkt_t;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.pkt_valid   = 1'b0;
    bus.data_in     = 8'h00;
    bus.fifo_full   = 1'b0;
    bus.detect_add  = 1'b0;
    bus.lfd_state   = 1'b0;
    bus.ld_state    = 1'b0;
    bus.laf_state   = 1'b0;
    bus.full_state  = 1'b0;
    bus.rst_int_reg = 1'b0;
  endtask

  task automatic full_stall(input int n, input logic [7:0] held);
    bus.full_state = 1'b1;
    for (int k = 0; k < n; k++) begin
      bus.data_in = 8'($urandom);
      step();
      chk("dout_hold_in_full", bus.dout, held);
    end
    bus.full_state = 1'b0;
  endtask

  // Reference: the header actually forwarded is the last one with address != 3.
  function automatic logic model_err(input pkt_t p, input logic [7:0] prev_hdr);
    logic [7:0] x;
    x = (p.hdr[1:0] != 2'b11) ? p.hdr : prev_hdr;
    for (int i = 0; i < p.len; i++) x = x ^ p.pay[i];
    return x != p.par;
  endfunction

  task automatic run_pkt(input pkt_t p);
    logic [7:0] hdr_out;
    logic [7:0] cur;
    hdr_out = (p.hdr[1:0] != 2'b11) ? p.hdr : last_hdr;

    bus.detect_add = 1'b1;
    bus.pkt_valid  = 1'b1;
    bus.data_in    = p.hdr;
    step();
    bus.detect_add = 1'b0;
    chk("pdone_clr_detect", bus.parity_done, 8'd0);
    last_hdr = hdr_out;

    bus.lfd_state = 1'b1;
    bus.data_in   = 8'($urandom);
    step();
    bus.lfd_state = 1'b0;
    chk("dout_header", bus.dout, hdr_out);
    chk("err_clr_lfd", bus.err, 8'd0);
    cur = hdr_out;

    for (int i = 0; i < p.len; i++) begin
      bus.ld_state  = 1'b1;
      bus.pkt_valid = 1'b1;
      bus.data_in   = p.pay[i];
      bus.fifo_full = p.stall[i];
      step();
      bus.ld_state  = 1'b0;
      bus.fifo_full = 1'b0;
      if (!p.stall[i]) begin
        chk("dout_payload", bus.dout, p.pay[i]);
      end else begin
        chk("dout_hold_ld_full", bus.dout, cur);
        full_stall(p.full_cyc, cur);
        bus.laf_state = 1'b1;
        bus.data_in   = 8'($urandom);
        step();
        bus.laf_state = 1'b0;
        chk("dout_replay", bus.dout, p.pay[i]);
      end
      cur = p.pay[i];
    end

    bus.ld_state  = 1'b1;
    bus.pkt_valid = 1'b0;
    bus.data_in   = p.par;
    bus.fifo_full = p.par_stall;
    step();
    bus.ld_state  = 1'b0;
    bus.fifo_full = 1'b0;
    chk("low_pkt_valid_set", bus.low_pkt_valid, 8'd1);
    if (!p.par_stall) begin
      chk("dout_parity", bus.dout, p.par);
      chk("parity_done", bus.parity_done, 8'd1);
    end else begin
      chk("pdone_low_when_full", bus.parity_done, 8'd0);
      chk("dout_hold_par_full", bus.dout, cur);
      full_stall(p.full_cyc, cur);
      bus.laf_state = 1'b1;
      bus.data_in   = 8'($urandom);
      step();
      bus.laf_state = 1'b0;
      chk("dout_parity_replay", bus.dout, p.par);
      chk("parity_done_laf", bus.parity_done, 8'd1);
    end

    bus.rst_int_reg = 1'b1;
    step();
    bus.rst_int_reg = 1'b0;
    chk("err", bus.err, {7'd0, p.exp_err});
    chk("low_pkt_valid_clr", bus.low_pkt_valid, 8'd0);
    step();
    chk("err_hold", bus.err, {7'd0, p.exp_err});
  endtask

  pkt_t tbl[5];
  pkt_t rp;

  initial begin
    tbl[0] = '{hdr: 8'h0D, len: 3, pay: {40'h0, 8'h33, 8'h22, 8'h11}, par: 8'h0D,
               stall: 8'h00, par_stall: 1'b0, full_cyc: 1, exp_err: 1'b0};
    tbl[1] = '{hdr: 8'h0D, len: 3, pay: {40'h0, 8'h33, 8'h22, 8'h11}, par: 8'hFF,
               stall: 8'h00, par_stall: 1'b0, full_cyc: 1, exp_err: 1'b1};
    tbl[2] = '{hdr: 8'h0D, len: 3, pay: {40'h0, 8'h33, 8'h22, 8'h11}, par: 8'h0D,
               stall: 8'h02, par_stall: 1'b0, full_cyc: 2, exp_err: 1'b0};
    tbl[3] = '{hdr: 8'h0D, len: 3, pay: {40'h0, 8'h33, 8'h22, 8'h11}, par: 8'h0D,
               stall: 8'h00, par_stall: 1'b1, full_cyc: 1, exp_err: 1'b0};
    // Address-3 header is dropped; the previous 0D header is what gets forwarded.
    tbl[4] = '{hdr: 8'h07, len: 3, pay: {40'h0, 8'h33, 8'h22, 8'h11}, par: 8'h0D,
               stall: 8'h00, par_stall: 1'b0, full_cyc: 1, exp_err: 1'b0};

    clear_inputs();
    resetn = 1'b0;
    bus.data_in = 8'hA5;
    step();
    step();
    chk("rst_dout", bus.dout, 8'd0);
    chk("rst_parity_done", bus.parity_done, 8'd0);
    chk("rst_low_pkt_valid", bus.low_pkt_valid, 8'd0);
    chk("rst_err", bus.err, 8'd0);
    resetn = 1'b1;
    last_hdr = 8'h00;
    clear_inputs();
    step();

    for (int t = 0; t < 5; t++) begin
      run_pkt(tbl[t]);
      clear_inputs();
    end

    // Reset on the edge that would have produced err=1 for a bad-parity packet.
    bus.detect_add = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 8'h0D; step();
    bus.detect_add = 1'b0; bus.lfd_state = 1'b1; step();
    bus.lfd_state = 1'b0; bus.ld_state = 1'b1; bus.data_in = 8'h11; step();
    bus.pkt_valid = 1'b0; bus.data_in = 8'hFF; step();
    chk("pre_rst_parity_done", bus.parity_done, 8'd1);
    resetn = 1'b0; bus.pkt_valid = 1'b1; bus.data_in = 8'h55; step();
    resetn = 1'b1;
    clear_inputs();
    chk("midrst_dout", bus.dout, 8'd0);
    chk("midrst_parity_done", bus.parity_done, 8'd0);
    chk("midrst_low_pkt_valid", bus.low_pkt_valid, 8'd0);
    chk("midrst_err", bus.err, 8'd0);
    last_hdr = 8'h00;
    step();
    run_pkt(tbl[0]);
    clear_inputs();

    for (int n = 0; n < 40; n++) begin
      rp.hdr = 8'($urandom);
      rp.len = int'($urandom_range(1, 8));
      for (int i = 0; i < 8; i++) rp.pay[i] = 8'($urandom);
      rp.stall     = 8'($urandom) & 8'($urandom);
      rp.par_stall = ($urandom_range(0, 3) == 0);
      rp.full_cyc  = int'($urandom_range(1, 3));
      begin
        logic [7:0] h;
        logic [7:0] good;
        h = (rp.hdr[1:0] != 2'b11) ? rp.hdr : last_hdr;
        good = h;
        for (int i = 0; i < rp.len; i++) good = good ^ rp.pay[i];
        rp.par = ($urandom_range(0, 1) == 0) ? good : 8'($urandom);
      end
      rp.exp_err = model_err(rp, last_hdr);
      run_pkt(rp);
      clear_inputs();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/router_register.md
# router_register

Datapath register stage of the 1x3 router, between the source-side packet interface and the three output FIFOs. Driven by the router control FSM's state decodes. It latches the header, forwards header/payload/parity bytes on `dout` toward the FIFO write port, and holds one byte while the destination FIFO is full. It also computes running XOR parity and reports `parity_done`, `low_pkt_valid` and the parity error `err`.

## Interface
- `WIDTH`, default 8: data byte width.
- `clk`  in  1  clock; all state updates on the rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `pkt_valid`  in  1  source byte valid; high for header and payload, low on the parity byte.
- `data_in`  in  WIDTH  source byte; `data_in[1:0]` of the header is the destination address.
- `fifo_full`  in  1  selected destination FIFO full.
- `detect_add`  in  1  FSM in address-decode state.
- `lfd_state`  in  1  FSM in load-first-data (header write) state.
- `ld_state`  in  1  FSM in load-data state.
- `laf_state`  in  1  FSM in load-after-full state.
- `full_state`  in  1  FSM in FIFO-full state.
- `rst_int_reg`  in  1  FSM in check-parity state; clears `low_pkt_valid`.
- `dout`  out  WIDTH  byte presented to the FIFO write port.
- `parity_done`  out  1  parity byte captured for the current packet.
- `low_pkt_valid`  out  1  `pkt_valid` seen low during load-data.
- `err`  out  1  computed parity differs from received parity.

## Operation
- Internal registers, all WIDTH wide and 0 on reset:
  - `header_byte`
  - `full_byte`: byte held while the FIFO is full.
  - `internal_parity`
  - `packet_parity`
- State inputs are one-hot by construction; behaviour under multiple asserted state inputs is undefined.
- **`header_byte` capture:** when `detect_add & pkt_valid & data_in[1:0]!=2'b11`, `header_byte<=data_in`. Address 3 is ignored and `header_byte` holds.
- **`dout` update, first matching rule applies:**
  1. `lfd_state`: `dout<=header_byte`.
  2. `ld_state & !fifo_full`: `dout<=data_in`.
  3. `ld_state & fifo_full`: `full_byte<=data_in`, `dout` holds.
  4. `laf_state`: `dout<=full_byte`.
  5. Otherwise `dout` holds.
- **`internal_parity`:**
  - Cleared on `detect_add`.
  - `lfd_state`: `^= header_byte`.
  - `ld_state & pkt_valid & !full_state`: `^= data_in`. This applies whether or not `fifo_full` is set; every payload byte is counted exactly once.
- **`packet_parity`:**
  - Cleared on `detect_add`.
  - `ld_state & !pkt_valid & !fifo_full`: `<=data_in`.
  - `laf_state & low_pkt_valid & !parity_done`: `<=full_byte`. This covers a parity byte that arrived while the FIFO was full.
- **`parity_done`:**
  - Cleared on `detect_add`.
  - Set on `ld_state & !pkt_valid & !fifo_full` or on `laf_state & low_pkt_valid & !parity_done`.
  - Otherwise holds.
- **`low_pkt_valid`:**
  - Cleared on `rst_int_reg`.
  - Set on `ld_state & !pkt_valid`.
  - Otherwise holds.
- **`err`:**
  - Cleared on `lfd_state`.
  - While `parity_done`=1: `err<=(internal_parity!=packet_parity)`.
  - Otherwise holds, so the value stays visible until the next packet's header write.

## Timing
- **Reset:** `resetn`=0 at a rising edge forces `dout`, `parity_done`, `low_pkt_valid`, `err` and all internal registers to 0, overriding every other condition, including mid-packet.
- **Packet latencies** (one rising edge = one cycle):
  - Header presented in the `detect_add` cycle appears on `dout` one cycle after `lfd_state`.
  - Each payload byte accepted in `ld_state` appears on `dout` after 1 cycle.
  - Parity byte: `dout`, `packet_parity`, `parity_done` and `low_pkt_valid` update on the same edge.
  - `err` is valid one cycle after `parity_done` rises.
- **Full stall:**
  - The byte presented in the `ld_state & fifo_full` cycle is held in `full_byte`.
  - The source is stalled by FSM `busy` for the whole `full_state` period; `data_in` is ignored then.
  - `full_byte` is replayed on `dout` one cycle after `laf_state`.
- **Simultaneous events:** in `ld_state` with `!pkt_valid & fifo_full`, `low_pkt_valid` sets but `parity_done` does not.
- **New packet:** the `detect_add` cycle clears `parity_done` and both parity registers on the same edge that captures the new header.

## Test plan
- **Correct parity:** header 8'h0D (len 3, addr 1), payload 8'h11, 8'h22, 8'h33, parity 8'h0D^8'h11^8'h22^8'h33=8'h0D.
  - `dout` sequence: 0D, 11, 22, 33, 0D.
  - `parity_done`=1 on the parity edge; `err`=0 one cycle later.
- **Bad parity:** same packet with parity byte 8'hFF.
  - `err`=1 one cycle after `parity_done`.
  - `err` stays 1 until the next `lfd_state`, then returns to 0.
- **Full mid-payload:** `fifo_full`=1 while payload 8'h22 is presented in `ld_state`.
  - `dout` holds 8'h11.
  - After `laf_state`, `dout`=8'h22.
  - Final `err`=0 and `internal_parity` matches the fault-free case.
- **Parity byte while full:** `ld_state`, `pkt_valid`=0, `fifo_full`=1, `data_in`=8'h0D.
  - `low_pkt_valid`=1 and `parity_done`=0.
  - In `laf_state`: `packet_parity`=8'h0D and `parity_done`=1; then `err`=0.
- **Address 3 header:** `detect_add`, `pkt_valid`=1, `data_in`=8'h07 → `header_byte` unchanged.
- **Reset mid-packet:** `resetn`=0 for one edge during `ld_state` → all outputs 0 on the next cycle; a following clean packet produces correct `dout` and `err`=0.
